// File: rtl/bp_sample_feeder.sv
// bp_sample_feeder: buffers training samples and sequences them into the back-prop core per iteration/epoch
module bp_sample_feeder #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int EPOCHS = 64,
  parameter int EW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [53:0]   load_data,
  input  logic          clear,
  input  logic          start,
  input  logic          iter_done,
  output logic [8:0]    x0,
  output logic [8:0]    x1,
  output logic [8:0]    x2,
  output logic [8:0]    x3,
  output logic [8:0]    desired_y0,
  output logic [8:0]    desired_y1,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          err_empty,
  output logic [AW-1:0] sample_idx,
  output logic [EW-1:0] epoch,
  output logic [AW:0]   count
);
  typedef enum logic [2:0] {IDLE, PRIME, RUN, ADVANCE, DONE} state_t;
  state_t state, state_n;
  logic [53:0] mem [DEPTH];
  logic [AW:0] count_n;
  logic [AW-1:0] idx_n;
  logic [EW-1:0] epoch_n;
  logic idle, wr, last, err_n;
  always_comb begin
    idle    = state == IDLE || state == DONE;
    wr      = idle && load_valid && load_ready && !clear;
    count_n = (idle && clear) ? '0 : count + (AW+1)'(wr);
    last    = (AW+1)'(sample_idx) == count - (AW+1)'(1);
    state_n = state;
    idx_n   = sample_idx;
    epoch_n = epoch;
    err_n   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          err_n   = count_n == '0;
          state_n = (count_n == '0) ? IDLE : PRIME;
          idx_n   = '0;
          epoch_n = (count_n == '0) ? epoch : '0;
        end else if (wr || clear) state_n = IDLE;
      end
      PRIME:   state_n = RUN;
      ADVANCE: state_n = RUN;
      RUN: if (iter_done) begin
        idx_n   = last ? '0 : sample_idx + AW'(1);
        epoch_n = last ? epoch + EW'(1) : epoch;
        state_n = (last && epoch_n == EW'(EPOCHS)) ? DONE : ADVANCE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (wr && !reset) mem[count[AW-1:0]] <= load_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      sample_idx <= '0;
      epoch      <= '0;
      {desired_y1, desired_y0, x3, x2, x1, x0} <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_empty  <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state      <= state_n;
      count      <= count_n;
      sample_idx <= idx_n;
      epoch      <= epoch_n;
      core_rst   <= state_n != RUN;
      busy       <= state_n == PRIME || state_n == RUN || state_n == ADVANCE;
      done       <= state_n == DONE;
      err_empty  <= err_n;
      load_ready <= (state_n == IDLE || state_n == DONE) && count_n != (AW+1)'(DEPTH);
      // sample only moves while the core is held in reset
      if (state == PRIME || state == ADVANCE)
        {desired_y1, desired_y0, x3, x2, x1, x0} <= mem[sample_idx];
    end
  end
endmodule

// File: tb/tb_bp_sample_feeder.sv
// tb_bp_sample_feeder: directed scoreboard bench for bp_sample_feeder with EPOCHS=2
module tb_bp_sample_feeder;
  logic clk = 0, reset = 1, load_valid = 0, clear = 0, start = 0, iter_done = 0;
  logic [53:0] load_data = '0;
  logic load_ready, core_rst, busy, done, err_empty;
  logic [8:0] x0, x1, x2, x3, desired_y0, desired_y1;
  logic [3:0] sample_idx;
  logic [7:0] epoch;
  logic [4:0] count;
  logic [53:0] obs;
  logic [53:0] mdl [16];
  logic [53:0] q [$];
  logic [53:0] nd;
  int mcount = 0, total = 0, bad = 0;
  assign obs = {desired_y1, desired_y0, x3, x2, x1, x0};
  always #5 clk = ~clk;
  bp_sample_feeder #(.DEPTH(16), .AW(4), .EPOCHS(2), .EW(8)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .clear(clear), .start(start), .iter_done(iter_done),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .desired_y0(desired_y0), .desired_y1(desired_y1),
    .core_rst(core_rst), .busy(busy), .done(done), .err_empty(err_empty),
    .sample_idx(sample_idx), .epoch(epoch), .count(count));
  function automatic logic [53:0] smp(input int a, input int b, input int c);
    return {9'(c), 9'(-a), 9'(b), 9'(a + 2), 9'(a + 1), 9'(a)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [53:0] d);
    load_valid = 1;
    load_data = d;
    tick;
    load_valid = 0;
    if (mcount < 16) begin
      mdl[mcount] = d;
      mcount++;
    end
  endtask
  task automatic go;
    start = 1;
    tick;
    start = 0;
    for (int e = 0; e < 2; e++)
      for (int i = 0; i < mcount; i++) q.push_back(mdl[i]);
    tick;
  endtask
  task automatic present(input string tag);
    logic [53:0] e;
    e = (q.size() != 0) ? q.pop_front() : 'x;
    chk({tag, "_rst"}, 64'(core_rst), 64'(0));
    chk({tag, "_data"}, 64'(obs), 64'(e));
  endtask
  task automatic pulse;
    iter_done = 1;
    tick;
    iter_done = 0;
  endtask
  task automatic do_reset;
    reset = 1;
    tick;
    reset = 0;
    q.delete();
    mcount = 0;
  endtask
  initial begin
    tick;
    do_reset;
    chk("rst_count", 64'(count), 0);
    chk("rst_core_rst", 64'(core_rst), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_ready", 64'(load_ready), 1);
    chk("rst_data", 64'(obs), 0);
    chk("rst_epoch", 64'(epoch), 0);
    for (int i = 1; i <= 3; i++) load(smp(10 * i, 3 * i, -i));
    chk("count3", 64'(count), 3);
    go;
    present("p0");
    tick;
    chk("hold_data", 64'(x0), 64'(10));
    for (int k = 1; k <= 6; k++) begin
      pulse;
      if (k < 6) begin
        chk("adv_rst", 64'(core_rst), 1);
        if (k == 3) chk("epoch1", 64'(epoch), 1);
        tick;
        present("seq");
      end else begin
        chk("fin_done", 64'(done), 1);
        chk("fin_busy", 64'(busy), 0);
        chk("fin_core_rst", 64'(core_rst), 1);
        chk("fin_epoch", 64'(epoch), 2);
      end
    end
    chk("sb_drain", 64'(q.size()), 0);
    pulse;
    chk("ign_iter_done", 64'(done), 1);
    chk("ign_iter_epoch", 64'(epoch), 2);
    go;
    present("r0");
    pulse; tick; present("r1");
    pulse; tick; present("r2");
    chk("run_idx2", 64'(sample_idx), 2);
    load_valid = 1;
    load_data = smp(99, 0, 0);
    tick;
    load_valid = 0;
    chk("run_no_load", 64'(count), 3);
    chk("run_ready", 64'(load_ready), 0);
    nd = mdl[0];
    reset = 1;
    tick;
    reset = 0;
    chk("mid_rst_core", 64'(core_rst), 1);
    chk("mid_rst_idx", 64'(sample_idx), 0);
    chk("mid_rst_epoch", 64'(epoch), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_count", 64'(count), 0);
    q.delete();
    mcount = 0;
    for (int i = 1; i <= 3; i++) load(smp(10 * i, 3 * i, -i));
    go;
    present("replay");
    chk("replay_x0", 64'(x0), 64'(10));
    do_reset;
    clear = 1;
    load_valid = 1;
    load_data = smp(77, 0, 0);
    tick;
    clear = 0;
    load_valid = 0;
    chk("clear_wins", 64'(count), 0);
    start = 1;
    tick;
    start = 0;
    chk("err_pulse", 64'(err_empty), 1);
    chk("err_busy", 64'(busy), 0);
    chk("err_core_rst", 64'(core_rst), 1);
    tick;
    chk("err_once", 64'(err_empty), 0);
    nd = smp(5, -200, -1);
    load_valid = 1;
    load_data = nd;
    start = 1;
    tick;
    load_valid = 0;
    start = 0;
    mdl[0] = nd;
    mcount = 1;
    for (int e = 0; e < 2; e++) q.push_back(nd);
    chk("ld_start_err", 64'(err_empty), 0);
    chk("ld_start_busy", 64'(busy), 1);
    chk("ld_start_count", 64'(count), 1);
    tick;
    present("neg");
    chk("neg_x3", 64'(x3), 64'h138);
    chk("neg_dy1", 64'(desired_y1), 64'h1FF);
    do_reset;
    for (int i = 0; i < 16; i++) load(smp(100 + i, i, i));
    chk("full_count", 64'(count), 16);
    chk("full_ready", 64'(load_ready), 0);
    load_valid = 1;
    load_data = smp(-7, 1, 1);
    tick;
    load_valid = 0;
    chk("full_blocked", 64'(count), 16);
    go;
    present("full0");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
